// File: rtl/data_inf_c_sched_pkg.sv
// data_inf_c_sched_pkg: shared state type and round-robin picker for the s2m scheduler
package data_inf_c_sched_pkg;
  typedef enum logic {IDLE, XFER} state_e;
  localparam int MAX_NUM = 16;
  // Returns {found, idx}: first set req bit scanning ptr+1, ptr+2, ... modulo num
  function automatic logic [4:0] rr_pick(input logic [MAX_NUM-1:0] req, input logic [3:0] ptr, input int num);
    logic [4:0] r;
    int k;
    r = '0;
    for (int i = MAX_NUM; i >= 1; i--) begin
      k = (int'(ptr) + i) % num;
      if (i <= num && req[k]) r = {1'b1, 4'(k)};
    end
    return r;
  endfunction
endpackage

// File: rtl/data_inf_c_credit_cnt.sv
// data_inf_c_credit_cnt: saturating up/down credit counter with sticky overflow flag
module data_inf_c_credit_cnt #(
  parameter int CREDITS = 4,
  parameter int CSIZE = $clog2(CREDITS+1)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             dec,
  input  logic             inc,
  output logic [CSIZE-1:0] cnt,
  output logic             ovf
);
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      cnt <= CSIZE'(CREDITS);
      ovf <= 1'b0;
    end else if (inc && !dec) begin
      if (cnt == CSIZE'(CREDITS)) ovf <= 1'b1;
      else cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/data_inf_c_s2m_scheduler.sv
// data_inf_c_s2m_scheduler: per-packet round-robin destination scheduler with credits
module data_inf_c_s2m_scheduler #(
  parameter int NUM = 8,
  parameter int NSIZE = $clog2(NUM),
  parameter int CREDITS = 4,
  parameter int CSIZE = $clog2(CREDITS+1)
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 up_valid,
  input  logic                 up_last,
  output logic                 up_ready,
  output logic                 ic_valid,
  input  logic                 ic_ready,
  output logic [NSIZE-1:0]     addr,
  input  logic [NUM-1:0]       dest_en,
  input  logic [NUM-1:0]       credit_ret,
  output logic [NUM*CSIZE-1:0] credit_cnt,
  output logic                 busy,
  output logic                 credit_ovf
);
  import data_inf_c_sched_pkg::*;
  state_e state;
  logic gate, grant;
  logic [NSIZE-1:0] rr_ptr;
  logic [NUM-1:0] elig, dec, ovf;
  logic [4:0] pick;
  assign gate = state == XFER;
  assign busy = gate;
  assign up_ready = ic_ready & gate;
  assign ic_valid = up_valid & gate;
  assign pick = rr_pick(16'(elig), 4'(rr_ptr), NUM);
  assign grant = ~gate & up_valid & pick[4];
  assign credit_ovf = |ovf;
  for (genvar i = 0; i < NUM; i++) begin : g_cnt
    data_inf_c_credit_cnt #(.CREDITS(CREDITS), .CSIZE(CSIZE)) u_cnt (
      .clock(clock),
      .rst_n(rst_n),
      .dec(dec[i]),
      .inc(credit_ret[i]),
      .cnt(credit_cnt[i*CSIZE +: CSIZE]),
      .ovf(ovf[i])
    );
    assign elig[i] = dest_en[i] & (credit_cnt[i*CSIZE +: CSIZE] != '0);
    assign dec[i] = grant & (pick[3:0] == 4'(i));
  end
  // addr only changes on a grant, so it is stable for every beat of the packet
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      rr_ptr <= NSIZE'(NUM-1);
    end else if (state == IDLE) begin
      if (grant) begin
        state <= XFER;
        addr <= NSIZE'(pick[3:0]);
        rr_ptr <= NSIZE'(pick[3:0]);
      end
    end else if (up_valid && ic_ready && up_last) begin
      state <= IDLE;
    end
endmodule

// File: tb/tb_data_inf_c_s2m_scheduler.sv
// tb_data_inf_c_s2m_scheduler: random + directed bench against a packet-level reference model
module tb_data_inf_c_s2m_scheduler;
  localparam int NUM = 4, CREDITS = 4, CSIZE = 3;
  logic clock = 1'b0, rst_n = 1'b0;
  logic up_valid = 1'b0, up_last = 1'b0, ic_ready = 1'b0;
  logic [NUM-1:0] dest_en = '0, credit_ret = '0;
  logic up_ready, ic_valid, busy, credit_ovf;
  logic [1:0] addr;
  logic [NUM*CSIZE-1:0] credit_cnt;
  int tests = 0, fails = 0;
  bit m_busy, m_ovf;
  int m_addr, m_ptr, m_fires = 0, d_fires = 0, seen_addr = -1;
  int m_cr[NUM];

  data_inf_c_s2m_scheduler #(.NUM(NUM), .CREDITS(CREDITS)) dut (
    .clock(clock), .rst_n(rst_n), .up_valid(up_valid), .up_last(up_last),
    .up_ready(up_ready), .ic_valid(ic_valid), .ic_ready(ic_ready), .addr(addr),
    .dest_en(dest_en), .credit_ret(credit_ret), .credit_cnt(credit_cnt),
    .busy(busy), .credit_ovf(credit_ovf)
  );

  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_addr = 0; m_ptr = NUM-1; m_ovf = 0;
    foreach (m_cr[k]) m_cr[k] = CREDITS;
  endtask

  task automatic compare();
    chk("busy", busy, m_busy);
    chk("up_ready", up_ready, ic_ready & m_busy);
    chk("ic_valid", ic_valid, up_valid & m_busy);
    chk("addr", addr, m_addr);
    for (int k = 0; k < NUM; k++) chk("credit_cnt", credit_cnt[k*CSIZE +: CSIZE], m_cr[k]);
    chk("credit_ovf", credit_ovf, m_ovf);
  endtask

  // Packet-level rules: pick winner from pre-edge credits, then apply grant/return arithmetic
  task automatic model_update();
    int w;
    w = -1;
    if (!m_busy) begin
      if (up_valid)
        for (int i = 1; i <= NUM; i++) begin
          int k;
          k = (m_ptr + i) % NUM;
          if (w < 0 && dest_en[k] && m_cr[k] > 0) w = k;
        end
      if (w >= 0) begin m_busy = 1; m_addr = w; m_ptr = w; end
    end else if (up_valid && ic_ready) begin
      m_fires++;
      if (up_last) m_busy = 0;
    end
    for (int k = 0; k < NUM; k++) begin
      if (w == k && !credit_ret[k]) m_cr[k]--;
      else if (w != k && credit_ret[k]) begin
        if (m_cr[k] == CREDITS) m_ovf = 1;
        else m_cr[k]++;
      end
    end
  endtask

  task automatic step(input logic v, input logic l, input logic r, input logic [3:0] en, input logic [3:0] ret);
    @(negedge clock);
    up_valid = v; up_last = l; ic_ready = r; dest_en = en; credit_ret = ret;
    #1;
    compare();
    if (up_valid && up_ready) begin d_fires++; seen_addr = int'(addr); end
    @(posedge clock);
    model_update();
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 0; up_valid = 0; up_last = 0; ic_ready = 0; dest_en = '0; credit_ret = '0;
    model_reset();
    repeat (2) @(negedge clock);
    rst_n = 1;
  endtask

  task automatic send_pkt(input int n, input bit bp, input logic [3:0] en1, input logic [3:0] en2,
                          input bit ret_last, output int a, output int cyc);
    int done, f0;
    logic r;
    done = 0; cyc = 0;
    while (done < n && cyc < 200) begin
      r = !bp || (cyc % 3 == 0);
      f0 = m_fires;
      step(1'b1, done == n-1, r, done >= 1 ? en2 : en1,
           (ret_last && m_busy && r && done == n-1) ? 4'(1 << m_addr) : 4'b0);
      if (m_fires != f0) done++;
      cyc++;
    end
    if (done < n) begin
      tests++; fails++;
      $display("FAIL pkt_timeout: got %0d beats required %0d", done, n);
    end
    a = seen_addr;
  endtask

  initial begin
    int a, c, d0;
    int exp_rr[6];
    logic [3:0] en;
    exp_rr = '{0, 1, 2, 3, 0, 1};
    model_reset();
    do_reset();
    ic_ready = 1;
    #1;
    chk("rst_up_ready", up_ready, 0);
    chk("rst_ic_valid", ic_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", addr, 0);
    chk("rst_credit_cnt", credit_cnt, 12'h924);
    chk("rst_ovf", credit_ovf, 0);
    // Fairness with credits returned at each packet end
    for (int i = 0; i < 6; i++) begin
      send_pkt(2, 0, 4'hf, 4'hf, 1, a, c);
      chk("rr_addr", a, exp_rr[i]);
      chk("rr_pkt_cycles", c, 3);
    end
    #1 chk("rr_credit_cnt", credit_cnt, 12'h924);
    // Exhaustion on a single enabled destination
    do_reset();
    for (int i = 0; i < CREDITS; i++) begin
      send_pkt(1, 0, 4'b0010, 4'b0010, 0, a, c);
      chk("exh_addr", a, 1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 4'b0010, 4'b0);
      #1;
      chk("exh_stall_busy", busy, 0);
      chk("exh_stall_up_ready", up_ready, 0);
      chk("exh_cnt1", credit_cnt[CSIZE +: CSIZE], 0);
    end
    step(1, 1, 1, 4'b0010, 4'b0010);
    #1 chk("exh_ret_busy", busy, 0);
    chk("exh_ret_cnt1", credit_cnt[CSIZE +: CSIZE], 1);
    step(1, 1, 1, 4'b0010, 4'b0);
    #1 chk("exh_grant_busy", busy, 1);
    chk("exh_grant_addr", addr, 1);
    step(1, 1, 1, 4'b0010, 4'b0);
    // Grant and return on the same destination, then return at full count
    do_reset();
    step(1, 1, 1, 4'b0100, 4'b0100);
    #1 chk("same_busy", busy, 1);
    chk("same_addr", addr, 2);
    chk("same_cnt2", credit_cnt[2*CSIZE +: CSIZE], 4);
    chk("same_ovf", credit_ovf, 0);
    step(1, 1, 1, 4'b0100, 4'b0);
    step(0, 0, 0, 4'b0100, 4'b0100);
    #1 chk("ovf_cnt2", credit_cnt[2*CSIZE +: CSIZE], 4);
    chk("ovf_set", credit_ovf, 1);
    repeat (3) step(0, 0, 0, 4'b0100, 4'b0);
    #1 chk("ovf_sticky", credit_ovf, 1);
    do_reset();
    #1 chk("ovf_cleared", credit_ovf, 0);
    // Backpressure on a 5-beat packet
    d0 = d_fires;
    send_pkt(5, 1, 4'hf, 4'hf, 0, a, c);
    chk("bp_addr", a, 0);
    chk("bp_cycles", c, 16);
    chk("bp_handshakes", d_fires - d0, 5);
    #1 chk("bp_idle", busy, 0);
    // Enable cleared mid-packet
    do_reset();
    send_pkt(3, 0, 4'b0001, 4'b1000, 0, a, c);
    chk("en_cur_addr", a, 0);
    send_pkt(1, 0, 4'b1000, 4'b1000, 0, a, c);
    chk("en_next_addr", a, 3);
    // Asynchronous reset on beat 2 of a 4-beat packet
    do_reset();
    send_pkt(1, 0, 4'hf, 4'hf, 0, a, c);
    step(1, 0, 1, 4'hf, 4'b0);
    step(1, 0, 1, 4'hf, 4'b0);
    @(negedge clock);
    up_valid = 1; up_last = 0; ic_ready = 1;
    #1 chk("pre_rst_ic_valid", ic_valid, 1);
    chk("pre_rst_addr", addr, 1);
    #1 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_up_ready", up_ready, 0);
    chk("arst_ic_valid", ic_valid, 0);
    chk("arst_addr", addr, 0);
    chk("arst_credit_cnt", credit_cnt, 12'h924);
    model_reset();
    @(negedge clock);
    up_valid = 0;
    rst_n = 1;
    send_pkt(2, 0, 4'hf, 4'hf, 0, a, c);
    chk("arst_first_addr", a, 0);
    // Randomized traffic against the model
    do_reset();
    en = 4'hf;
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] ret;
      if ($urandom_range(15) == 0) en = 4'($urandom_range(15));
      for (int k = 0; k < NUM; k++) ret[k] = ($urandom_range(9) == 0);
      step($urandom_range(3) != 0, $urandom_range(2) == 0, $urandom_range(3) != 0, en, ret);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
